// File: rtl/uart_pkg.sv
// Shared definitions for the UART-to-LED link: baud codes, divisor lookup,
// transmitter state encoding and frame constants.
package uart_pkg;

   // Rate codes presented on baud_select
   localparam logic [2:0] BAUD_300    = 3'b000;
   localparam logic [2:0] BAUD_1200   = 3'b001;
   localparam logic [2:0] BAUD_4800   = 3'b010;
   localparam logic [2:0] BAUD_9600   = 3'b011;
   localparam logic [2:0] BAUD_19200  = 3'b100;
   localparam logic [2:0] BAUD_38400  = 3'b101;
   localparam logic [2:0] BAUD_57600  = 3'b110;
   localparam logic [2:0] BAUD_115200 = 3'b111;

   // Width of the sample-tick divider; the slowest rate at 50 MHz needs 14 bits
   localparam int DIV_W = 16;

   // Frame layout: start + 8 data + parity + stop
   localparam int DATA_BITS  = 8;
   localparam int FRAME_BITS = 11;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_START  = 3'd1,
      ST_DATA   = 3'd2,
      ST_PARITY = 3'd3,
      ST_STOP   = 3'd4
   } tx_state_e;

   // Rounded clock cycles per sample tick for a rate code
   function automatic int unsigned baud_div(input logic [2:0] code,
                                            input int unsigned clk_hz,
                                            input int unsigned os);
      int unsigned baud;
      int unsigned den;
      case (code)
         BAUD_300:    baud = 300;
         BAUD_1200:   baud = 1200;
         BAUD_4800:   baud = 4800;
         BAUD_9600:   baud = 9600;
         BAUD_19200:  baud = 19200;
         BAUD_38400:  baud = 38400;
         BAUD_57600:  baud = 57600;
         default:     baud = 115200;
      endcase
      den = os * baud;
      return (clk_hz + den / 2) / den;
   endfunction

endpackage

// File: rtl/baud_controller.sv
// Sample-tick generator: one tick every DIV clocks for the selected rate.
// A restart pulse realigns the tick phase so a bit period starts cleanly.
module baud_controller
   import uart_pkg::*;
#(
   parameter int CLK_HZ     = 50000000,
   parameter int OVERSAMPLE = 16
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [2:0] baud_select,
   input  logic       restart,
   output logic       sample_tick
);

   logic [DIV_W-1:0] div_m1;
   logic [DIV_W-1:0] cnt_q;
   logic [DIV_W-1:0] cnt_d;

   // Terminal count for the current rate; >= guards against a stale count after a rate change
   always_comb begin
      div_m1      = DIV_W'(baud_div(baud_select, CLK_HZ, OVERSAMPLE) - 1);
      sample_tick = (cnt_q >= div_m1);
      if (restart || sample_tick) begin
         cnt_d = '0;
      end else begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   // Divider counter register
   always_ff @(posedge clk) begin
      if (!reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/uart_word_tx.sv
// UART word transmitter: sends a 16-bit word as two back-to-back 8E1 frames,
// high byte first, with a registered glitch-free TxD.
module uart_word_tx
   import uart_pkg::*;
#(
   parameter int CLK_HZ     = 50000000,
   parameter int OVERSAMPLE = 16
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [2:0]  baud_select,
   input  logic        Tx_EN,
   input  logic        Tx_WR,
   input  logic [15:0] Tx_WORD,
   output logic        TxD,
   output logic        Tx_BUSY,
   output logic        Tx_DONE
);

   localparam int TICK_W = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
   localparam int BIT_W  = $clog2(DATA_BITS);

   tx_state_e          state_q,    state_d;
   logic [TICK_W-1:0]  tick_cnt_q, tick_cnt_d;
   logic [BIT_W-1:0]   bit_cnt_q,  bit_cnt_d;
   logic               byte_idx_q, byte_idx_d;
   logic [15:0]        word_q,     word_d;
   logic [2:0]         baud_q,     baud_d;
   logic               txd_q,      txd_d;
   logic               busy_q,     busy_d;
   logic               done_q,     done_d;

   logic               restart;
   logic               sample_tick;
   logic               bit_end;
   logic [BIT_W-1:0]   bit_cnt_inc;
   logic [7:0]         cur_byte;

   // Tick source runs from the rate latched at acceptance, not the live input
   baud_controller #(
      .CLK_HZ     (CLK_HZ),
      .OVERSAMPLE (OVERSAMPLE)
   ) u_baud (
      .clk         (clk),
      .reset       (reset),
      .baud_select (baud_q),
      .restart     (restart),
      .sample_tick (sample_tick)
   );

   // Next-state and next-output logic; outputs are computed one cycle ahead so they come straight from flops
   always_comb begin
      state_d     = state_q;
      tick_cnt_d  = tick_cnt_q;
      bit_cnt_d   = bit_cnt_q;
      byte_idx_d  = byte_idx_q;
      word_d      = word_q;
      baud_d      = baud_q;
      txd_d       = txd_q;
      busy_d      = busy_q;
      done_d      = 1'b0;
      restart     = 1'b0;
      cur_byte    = byte_idx_q ? word_q[7:0] : word_q[15:8];
      bit_cnt_inc = bit_cnt_q + 1'b1;
      bit_end     = sample_tick && (tick_cnt_q == TICK_W'(OVERSAMPLE - 1));

      if (state_q == ST_IDLE) begin
         txd_d  = 1'b1;
         busy_d = 1'b0;
         if (Tx_EN && Tx_WR) begin
            state_d    = ST_START;
            word_d     = Tx_WORD;
            baud_d     = baud_select;
            restart    = 1'b1;
            tick_cnt_d = '0;
            bit_cnt_d  = '0;
            byte_idx_d = 1'b0;
            txd_d      = 1'b0;
            busy_d     = 1'b1;
         end
      end else if (sample_tick) begin
         tick_cnt_d = bit_end ? '0 : tick_cnt_q + 1'b1;
         if (bit_end) begin
            case (state_q)
               ST_START: begin
                  state_d   = ST_DATA;
                  bit_cnt_d = '0;
                  txd_d     = cur_byte[0];
               end
               ST_DATA: begin
                  if (bit_cnt_q == BIT_W'(DATA_BITS - 1)) begin
                     state_d = ST_PARITY;
                     txd_d   = ^cur_byte;
                  end else begin
                     bit_cnt_d = bit_cnt_inc;
                     txd_d     = cur_byte[bit_cnt_inc];
                  end
               end
               ST_PARITY: begin
                  state_d = ST_STOP;
                  txd_d   = 1'b1;
               end
               ST_STOP: begin
                  if (!byte_idx_q) begin
                     // Low byte follows immediately, no idle gap between frames
                     state_d    = ST_START;
                     byte_idx_d = 1'b1;
                     txd_d      = 1'b0;
                  end else begin
                     state_d    = ST_IDLE;
                     byte_idx_d = 1'b0;
                     txd_d      = 1'b1;
                     busy_d     = 1'b0;
                     done_d     = 1'b1;
                  end
               end
               default: begin
                  state_d = ST_IDLE;
                  txd_d   = 1'b1;
                  busy_d  = 1'b0;
               end
            endcase
         end
      end
   end

   // FSM and output registers; reset wins over everything, even mid-frame
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q    <= ST_IDLE;
         tick_cnt_q <= '0;
         bit_cnt_q  <= '0;
         byte_idx_q <= 1'b0;
         word_q     <= '0;
         baud_q     <= '0;
         txd_q      <= 1'b1;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         tick_cnt_q <= tick_cnt_d;
         bit_cnt_q  <= bit_cnt_d;
         byte_idx_q <= byte_idx_d;
         word_q     <= word_d;
         baud_q     <= baud_d;
         txd_q      <= txd_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
      end
   end

   assign TxD     = txd_q;
   assign Tx_BUSY = busy_q;
   assign Tx_DONE = done_q;

endmodule

// File: tb/tb_uart_word_tx.sv
// Self-checking bench for uart_word_tx: expected line waveform is derived
// from the frame rules and the published divisor table.
module tb_uart_word_tx;

   logic        clk = 1'b0;
   logic        reset;
   logic [2:0]  baud_select;
   logic        Tx_EN;
   logic        Tx_WR;
   logic [15:0] Tx_WORD;
   logic        TxD;
   logic        Tx_BUSY;
   logic        Tx_DONE;

   int total_cnt = 0;
   int bad_cnt   = 0;

   uart_word_tx #(
      .CLK_HZ     (50000000),
      .OVERSAMPLE (16)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .baud_select (baud_select),
      .Tx_EN       (Tx_EN),
      .Tx_WR       (Tx_WR),
      .Tx_WORD     (Tx_WORD),
      .TxD         (TxD),
      .Tx_BUSY     (Tx_BUSY),
      .Tx_DONE     (Tx_DONE)
   );

   always #10 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total_cnt++;
      if (got !== exp) begin
         bad_cnt++;
         $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
      end
   endtask

   // Cycles per sample tick at 50 MHz, straight from the rate table
   function automatic int div_of(input int code);
      case (code)
         0: return 10417;
         1: return 2604;
         2: return 651;
         3: return 326;
         4: return 163;
         5: return 81;
         6: return 54;
         default: return 27;
      endcase
   endfunction

   // Line level for bit b (0..21) of the two-frame word
   function automatic logic exp_bit(input logic [15:0] w, input int b);
      logic [7:0] by;
      int f;
      by = (b < 11) ? w[15:8] : w[7:0];
      f  = b % 11;
      if (f == 0) return 1'b0;
      if (f <= 8) return by[f-1];
      if (f == 9) return logic'(($countones(by) % 2) == 1);
      return 1'b1;
   endfunction

   task automatic check_idle(input string tag);
      check({tag, "_txd"},  TxD,     1);
      check({tag, "_busy"}, Tx_BUSY, 0);
      check({tag, "_done"}, Tx_DONE, 0);
   endtask

   // Present a word at a negedge; accepted at the following posedge
   task automatic drive_accept(input logic [15:0] w, input int code);
      Tx_WORD     = w;
      baud_select = 3'(code);
      Tx_EN       = 1'b1;
      Tx_WR       = 1'b1;
   endtask

   // Follow one word from acceptance to DONE, checking every bit at start, middle and end
   task automatic watch_word(input logic [15:0] w, input int code, input bit hold,
                             input logic [15:0] nxt, input bit disturb);
      int bitlen, total, busy_low, done_seen, b, p;
      bitlen    = 16 * div_of(code);
      total     = 22 * bitlen;
      busy_low  = 0;
      done_seen = 0;
      for (int k = 1; k <= total; k++) begin
         @(negedge clk);
         b = (k - 1) / bitlen;
         p = (k - 1) % bitlen;
         if (p == 0 || p == bitlen / 2 || p == bitlen - 1)
            check($sformatf("txd_w%04h_b%0d_p%0d", w, b, p), TxD, exp_bit(w, b));
         if (!Tx_BUSY) busy_low++;
         if (Tx_DONE)  done_seen++;
         if (k == 1 && !hold) Tx_WR = 1'b0;
         if (disturb) begin
            if (k == total / 4) baud_select = ~baud_select;
            if (k == total / 3) begin
               Tx_WORD = 16'h1234;
               Tx_WR   = 1'b1;
            end
            if (k == total / 3 + 1) Tx_WR = 1'b0;
            if (k == total / 2) Tx_EN = 1'b0;
         end
      end
      check($sformatf("busy_gaps_w%04h", w), busy_low, 0);
      check($sformatf("early_done_w%04h", w), done_seen, 0);
      @(negedge clk);
      check($sformatf("done_w%04h", w), Tx_DONE, 1);
      check($sformatf("busy_at_done_w%04h", w), Tx_BUSY, 0);
      check($sformatf("txd_at_done_w%04h", w), TxD, 1);
      if (hold) begin
         Tx_WORD = nxt;
      end else begin
         @(negedge clk);
         check($sformatf("done_pulse_end_w%04h", w), Tx_DONE, 0);
         check($sformatf("idle_busy_w%04h", w), Tx_BUSY, 0);
      end
   endtask

   initial begin
      logic [15:0] w0, w1, w2;
      int cut;
      reset       = 1'b0;
      baud_select = 3'd7;
      Tx_EN       = 1'b0;
      Tx_WR       = 1'b0;
      Tx_WORD     = 16'h0000;

      // Reset held for five cycles, then released with no write
      repeat (5) begin
         @(negedge clk);
         check_idle("in_reset");
      end
      reset = 1'b1;
      repeat (10) begin
         @(negedge clk);
         check_idle("after_reset");
      end

      // Write strobes while disabled must not start anything
      Tx_EN   = 1'b0;
      Tx_WR   = 1'b1;
      Tx_WORD = 16'hFFFF;
      repeat (40) begin
         @(negedge clk);
         check_idle("en_off");
      end
      Tx_WR = 1'b0;
      @(negedge clk);

      // Reference word with a mid-word write, enable drop and rate change
      drive_accept(16'hDA8A, 7);
      watch_word(16'hDA8A, 7, 1'b0, 16'h0000, 1'b1);

      // Reset in the middle of the first frame's data bits
      w0 = 16'($urandom);
      drive_accept(w0, 7);
      cut = 3 * 432 + 100;
      for (int k = 1; k <= cut; k++) begin
         @(negedge clk);
         if (k == 1) Tx_WR = 1'b0;
      end
      check("busy_before_reset", Tx_BUSY, 1);
      check("txd_before_reset", TxD, exp_bit(w0, 3));
      reset = 1'b0;
      @(negedge clk);
      check_idle("midword_reset");
      reset = 1'b1;
      repeat (20) begin
         @(negedge clk);
         check_idle("post_abort");
      end

      // Back-to-back words with Tx_WR held through DONE
      w1 = 16'($urandom) | 16'h0100;
      w2 = 16'($urandom);
      drive_accept(w1, 7);
      watch_word(w1, 7, 1'b1, w2, 1'b0);
      watch_word(w2, 7, 1'b0, 16'h0000, 1'b0);

      // Even parity of 0x00 and 0xFF is 0 in both frames, at a slower rate
      @(negedge clk);
      drive_accept(16'h00FF, 6);
      watch_word(16'h00FF, 6, 1'b0, 16'h0000, 1'b1);

      $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
      $finish;
   end

endmodule

// File: doc/uart_word_tx.md
Name: uart_word_tx

Overview:
- UART transmit side for the UART-to-LED link. It serialises one 16-bit word as two consecutive 11-bit frames on TxD: high byte first, then low byte.
- Frame format: start bit, 8 data bits LSB-first, even parity, one stop bit. This is the format the receiver and LED display path expect.
- Contains its own baud-tick generator, selected by the same 3-bit baud_select code the receiver uses.

Parameters:
- CLK_HZ, 50000000, system clock frequency (the 20 ns period clock).
- OVERSAMPLE, 16, sample ticks per bit period; matches the receiver's oversampling.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- reset  in  1  synchronous, active-low reset.
- baud_select  in  3  rate code: 000=300, 001=1200, 010=4800, 011=9600, 100=19200, 101=38400, 110=57600, 111=115200 baud.
- Tx_EN  in  1  transmitter enable; a word is accepted only while high.
- Tx_WR  in  1  write strobe for Tx_WORD; level-sampled.
- Tx_WORD  in  16  word to send; [15:8] goes first.
- TxD  out  1  serial line; idles high.
- Tx_BUSY  out  1  high while a word is in flight.
- Tx_DONE  out  1  one-cycle pulse when the second stop bit completes.

Behaviour:
- Reset (reset==0 at a clock edge) takes effect that edge and overrides everything, including mid-frame:
  - TxD=1, Tx_BUSY=0, Tx_DONE=0.
  - FSM goes to IDLE; tick counter, bit counter and byte index clear.
- Tick divisor DIV = round(CLK_HZ/(OVERSAMPLE*baud)). At 50 MHz: 10417, 2604, 651, 326, 163, 81, 54, 27 for codes 000..111. One sample tick every DIV cycles; one bit = OVERSAMPLE ticks.
- Acceptance: a word is accepted at the edge where state==IDLE, Tx_EN==1 and Tx_WR==1.
  - Tx_WORD and baud_select are latched at that edge.
  - Tick counter restarts at that edge, so the start bit lasts exactly OVERSAMPLE*DIV cycles.
  - From the following cycle: Tx_BUSY=1 and TxD=0.
- Tx_WR while busy is ignored; there is no queue.
- A Tx_WR held high after Tx_DONE starts a new word in the cycle after DONE.
- Tx_EN low in IDLE blocks acceptance. Tx_EN dropping mid-word does not abort; the current word completes, so no truncated frames appear on the line.
- baud_select changes mid-word have no effect until the next acceptance.
- FSM states and transitions; each bit state lasts OVERSAMPLE ticks:
  - IDLE (TxD=1) -> START on acceptance.
  - START (TxD=0) -> DATA.
  - DATA: 8 bits, LSB of the current byte first -> PARITY.
  - PARITY: TxD = XOR of the 8 data bits (even parity) -> STOP.
  - STOP (TxD=1): if byte index==0, go to START for the low byte with no idle gap between frames; if byte index==1, go to IDLE.
- Completion: on the last cycle of the second STOP, Tx_DONE pulses for 1 cycle. Tx_BUSY falls at the same edge that Tx_DONE rises.
- Word duration: 22*OVERSAMPLE*DIV cycles, i.e. 9504 cycles (190.08 us) at 115200 baud.
- TxD is driven from a register and must be glitch-free.

Decomposition:
- Shared package uart_pkg holds:
  - baud code constants and the divisor lookup function;
  - FSM state encoding (IDLE, START, DATA, PARITY, STOP);
  - frame constants: DATA_BITS=8, FRAME_BITS=11.
- One sub-module, baud_controller: inputs clk, reset, baud_select, restart; output sample_tick. The receiver reuses it unchanged.

Test Plan:
- Reset held low for 5 cycles, then released, with Tx_WR=0 -> TxD=1, Tx_BUSY=0, Tx_DONE=0 throughout.
- baud 111, Tx_WORD=16'hDA8A, Tx_EN=Tx_WR=1 for one cycle -> TxD sequence:
  - first frame: 0, 0,1,0,1,1,0,1,1, parity 1, stop 1;
  - second frame: 0, 0,1,0,1,0,0,0,1, parity 1, stop 1;
  - each bit 432 cycles; Tx_DONE exactly 9504 cycles after acceptance.
- Second Tx_WR pulse with 16'h1234 issued mid-word -> ignored; only 16'hDA8A is sent; Tx_BUSY stays high continuously.
- Tx_EN=0 with Tx_WR=1 -> no activity. Tx_EN dropped mid-word -> word completes normally and Tx_DONE pulses.
- reset=0 asserted during the DATA bit of the first frame -> next edge TxD=1, Tx_BUSY=0. A new word accepted after release starts with a full-length start bit.
- baud 000, Tx_WORD=16'h00FF -> each bit lasts 166672 cycles; parity bit 0 in both frames; back-to-back frames with no idle gap.
